// File: rtl/instruction_fetch_unit.sv
// Prefetch buffer: small synchronous FIFO with a single-cycle flush.
// Latency: a pushed entry is visible at head_dat the cycle after the push.
// Backpressure: none internally; the caller guarantees no push when full and no pop when empty.
module ifu_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head_dat
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_vld) - CW'(pop_vld);
        end
    end

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clock) begin
        if (push_vld && !flush && !reset) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];

endmodule

// Instruction fetch: keeps fetch PC, issues one read at a time, buffers returned words for decode.
// Latency: first instruction reaches the decoder 2 cycles after gnt with a 1-cycle memory.
// Backpressure: decode_ready stalls the buffer head; fetch stops issuing once the buffer plus the in-flight slot is full.
module instruction_fetch_unit #(
    parameter int INSTRUCTION_WIDTH = 16,
    parameter int PC_WIDTH          = 32,
    parameter int QUEUE_DEPTH       = 2,
    parameter logic [PC_WIDTH-1:0]          RESET_PC           = '0,
    parameter logic [INSTRUCTION_WIDTH-1:0] BUBBLE_INSTRUCTION = 16'hE000
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic                         mem_req,
    output logic [PC_WIDTH-1:0]          mem_addr,
    input  logic                         mem_gnt,
    input  logic                         mem_rvalid,
    input  logic [INSTRUCTION_WIDTH-1:0] mem_rdata,
    output logic                         instr_valid,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic [PC_WIDTH-1:0]          instr_pc,
    input  logic                         decode_ready,
    input  logic                         redirect_valid,
    input  logic [PC_WIDTH-1:0]          redirect_pc,
    input  logic                         halt,
    output logic                         busy
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    typedef struct packed {
        logic [PC_WIDTH-1:0]          pc;
        logic [INSTRUCTION_WIDTH-1:0] instr;
    } fetch_entry_t;

    state_t                state, state_next;
    logic [PC_WIDTH-1:0]   fetch_pc, fetch_pc_next;
    logic                  discard, discard_next;
    logic [CW-1:0]         count, count_next;
    logic                  push, pop, room_after;
    fetch_entry_t          push_entry, head_entry;
    logic [$bits(fetch_entry_t)-1:0] head_dat;

    assign instr_valid = (count != '0);
    assign pop         = instr_valid && decode_ready && !redirect_valid;
    assign push        = (state == WAIT) && mem_rvalid && !discard && !redirect_valid;
    assign count_next  = redirect_valid ? '0 : count + CW'(push) - CW'(pop);
    assign room_after  = (int'(count_next) + 1) <= QUEUE_DEPTH;

    // In WAIT fetch_pc has already advanced past the outstanding request.
    assign push_entry.pc    = fetch_pc - 1'b1;
    assign push_entry.instr = mem_rdata;

    ifu_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (QUEUE_DEPTH)
    ) u_buf (
        .clock    (clock),
        .reset    (reset),
        .flush    (redirect_valid),
        .push_vld (push),
        .push_dat (push_entry),
        .pop_vld  (pop),
        .count    (count),
        .head_dat (head_dat)
    );

    assign head_entry = head_dat;

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        discard_next  = discard && !mem_rvalid;
        unique case (state)
            IDLE: begin
                // Hold off while a stale response is still due, so only one read is ever in flight.
                if (!halt && !redirect_valid && !discard && (int'(count) < QUEUE_DEPTH))
                    state_next = REQ;
            end
            REQ: begin
                if (mem_gnt) begin
                    state_next    = WAIT;
                    fetch_pc_next = fetch_pc + 1'b1;
                    discard_next  = redirect_valid;
                end else if (redirect_valid) begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (mem_rvalid)
                    state_next = (!halt && !redirect_valid && room_after) ? REQ : IDLE;
                else if (redirect_valid)
                    discard_next = 1'b1;
            end
            default: state_next = IDLE;
        endcase
        if (redirect_valid) fetch_pc_next = redirect_pc;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            // A read accepted before reset still returns; remember to drop it.
            discard  <= ((state == WAIT || discard) && !mem_rvalid) || (state == REQ && mem_gnt);
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            discard  <= discard_next;
        end
    end

    assign mem_req     = (state == REQ);
    assign mem_addr    = fetch_pc;
    assign instruction = instr_valid ? head_entry.instr : BUBBLE_INSTRUCTION;
    assign instr_pc    = instr_valid ? head_entry.pc : '0;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomised bench for instruction_fetch_unit against a transaction-level stream model.
module tb_instruction_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0;
    localparam logic [15:0] BUB   = 16'hE000;

    logic        clock = 1'b0;
    logic        reset, mem_req, mem_gnt, mem_rvalid, instr_valid;
    logic        decode_ready, redirect_valid, halt, busy;
    logic [31:0] mem_addr, instr_pc, redirect_pc;
    logic [15:0] mem_rdata, instruction;

    always #5 clock = ~clock;

    instruction_fetch_unit dut (
        .clock          (clock),
        .reset          (reset),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .instr_valid    (instr_valid),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .decode_ready   (decode_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .busy           (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stimulus knobs
    int   gnt_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1;
    logic halt_q = 1'b0;

    // Stream model: what the decoder should see and what memory should be asked for
    int          occ = 0, delivered = 0, delay = 0, cyc = 0, gnt_cyc = 0, ngnt = 0;
    logic [31:0] exp_pc = RPC, req_pc = RPC, out_addr = '0, last_pop_pc = '0, prev_addr = '0;
    logic [15:0] out_data = '0, last_pop_ins = '0;
    logic        out_pending = 0, out_stale = 0, reset_stale = 0;
    logic        prev_req = 0, prev_gnt = 0, prev_redir = 0, prev_halt = 0, prev_rst = 1;

    function automatic logic [15:0] data_of(input logic [31:0] a);
        return 16'h1000 + a[15:0];
    endfunction

    task automatic tick(input logic rst, input logic redir, input logic [31:0] rpc);
        logic rv;
        // Checks on the outputs of the current cycle
        check("valid", 32'(instr_valid), 32'(occ != 0));
        if (!instr_valid) begin
            check("bubble_ins", 32'(instruction), 32'(BUB));
            check("bubble_pc", instr_pc, 32'h0);
        end else begin
            check("head_pc", instr_pc, exp_pc);
            check("head_ins", 32'(instruction), 32'(data_of(exp_pc)));
        end
        if (out_pending) check("one_outstanding", 32'(mem_req), 32'h0);
        if (prev_req && !prev_gnt && !prev_redir && !prev_rst) begin
            check("req_hold", 32'(mem_req), 32'h1);
            check("addr_hold", mem_addr, prev_addr);
        end
        if (mem_req) check("req_addr", mem_addr, req_pc);
        if (mem_req && !prev_req) begin
            check("req_under_halt", 32'(prev_halt), 32'h0);
            check("req_room", 32'(occ < DEPTH), 32'h1);
        end
        if (!(out_pending && reset_stale))
            check("busy", 32'(busy), 32'(mem_req || out_pending));

        // Drive inputs for this cycle
        reset          = rst;
        redirect_valid = redir;
        redirect_pc    = rpc;
        halt           = halt_q;
        decode_ready   = int'($urandom_range(0, 99)) < rdy_pct;
        mem_gnt        = mem_req && !rst && (int'($urandom_range(0, 99)) < gnt_pct);
        rv             = out_pending && (delay == 0);
        mem_rvalid     = rv;
        mem_rdata      = rv ? out_data : 16'($urandom);

        // Effects at the coming edge
        if (rst) begin
            occ    = 0;
            exp_pc = RPC;
            req_pc = RPC;
            if (out_pending && !rv) begin
                out_stale   = 1;
                reset_stale = 1;
            end
        end else begin
            if (instr_valid && decode_ready && !redir && occ > 0) begin
                last_pop_pc  = exp_pc;
                last_pop_ins = instruction;
                exp_pc       = exp_pc + 1;
                occ--;
                delivered++;
            end
            if (rv && !out_stale && !redir) begin
                occ++;
                check("no_overflow", 32'(occ <= DEPTH), 32'h1);
            end
        end
        if (rv) begin
            out_pending = 0;
            out_stale   = 0;
            reset_stale = 0;
        end else if (out_pending) begin
            delay--;
        end
        if (mem_gnt) begin
            out_pending = 1;
            out_addr    = mem_addr;
            out_data    = data_of(mem_addr);
            out_stale   = redir;
            delay       = int'($urandom_range(lat_max - 1, lat_min - 1));
            req_pc      = mem_addr + 1;
            gnt_cyc     = cyc;
            ngnt++;
        end
        if (redir && !rst) begin
            occ    = 0;
            exp_pc = rpc;
            req_pc = rpc;
            if (out_pending && !mem_gnt) out_stale = 1;
        end

        prev_req   = mem_req;
        prev_gnt   = mem_gnt;
        prev_redir = redir;
        prev_halt  = halt_q;
        prev_rst   = rst;
        prev_addr  = mem_addr;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic tick0();
        tick(1'b0, 1'b0, '0);
    endtask

    initial begin
        int d0, g0, n;
        reset = 1; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; decode_ready = 0;
        redirect_valid = 0; redirect_pc = '0; halt = 0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_addr", mem_addr, RPC);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_ins", 32'(instruction), 32'(BUB));
        check("rst_pc", instr_pc, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // Streaming with a 1-cycle memory
        tick(1'b1, 1'b0, '0);
        for (int i = 0; i < 20 && !instr_valid; i++) tick0();
        check("t1_first_valid", 32'(instr_valid), 32'h1);
        check("t1_latency", 32'(cyc - gnt_cyc), 32'd2);
        check("t1_first_ins", 32'(instruction), 32'h1000);
        d0 = delivered;
        for (int i = 0; i < 20 && delivered < d0 + 3; i++) tick0();
        check("t1_delivered", 32'(delivered - d0), 32'd3);
        check("t1_last_pc", last_pop_pc, 32'd2);
        check("t1_last_ins", 32'(last_pop_ins), 32'h1002);

        // Stalled decoder fills exactly the buffer
        rdy_pct = 0;
        tick(1'b1, 1'b0, '0);
        g0 = ngnt;
        repeat (12) tick0();
        check("t2_grants", 32'(ngnt - g0), 32'd2);
        check("t2_req_idle", 32'(mem_req), 32'h0);
        check("t2_head_pc", instr_pc, 32'h0);
        rdy_pct = 100;
        d0 = delivered;
        n = 0;
        for (int i = 0; i < 20 && delivered < d0 + 3; i++) begin tick0(); n++; end
        check("t2_drain", 32'(delivered - d0), 32'd3);
        check("t2_last_pc", last_pop_pc, 32'd2);
        check("t2_refill_gap", 32'(n <= 5), 32'h1);

        // Redirect while waiting on PC 5
        lat_min = 3; lat_max = 3;
        tick(1'b1, 1'b0, '0);
        for (int i = 0; i < 80 && !(out_pending && out_addr == 32'd5); i++) tick0();
        check("t3_in_wait_pc5", 32'(out_pending && out_addr == 32'd5), 32'h1);
        tick(1'b0, 1'b1, 32'h800);
        check("t3_flushed", 32'(instr_valid), 32'h0);
        for (int i = 0; i < 20 && !mem_req; i++) tick0();
        check("t3_new_addr", mem_addr, 32'h800);
        d0 = delivered;
        for (int i = 0; i < 30 && delivered == d0; i++) tick0();
        check("t3_first_pc", last_pop_pc, 32'h800);
        check("t3_first_ins", 32'(last_pop_ins), 32'h1800);

        // Redirect coinciding with a pop and a response
        lat_min = 1; lat_max = 1; rdy_pct = 0;
        tick(1'b1, 1'b0, '0);
        for (int i = 0; i < 30 && !(instr_valid && out_pending && delay == 0); i++) tick0();
        check("t4_setup", 32'(instr_valid && out_pending && delay == 0), 32'h1);
        rdy_pct = 100;
        d0 = delivered;
        tick(1'b0, 1'b1, 32'h40);
        check("t4_no_old_pop", 32'(delivered - d0), 32'h0);
        check("t4_flushed", 32'(instr_valid), 32'h0);
        for (int i = 0; i < 30 && delivered == d0; i++) tick0();
        check("t4_first_pc", last_pop_pc, 32'h40);

        // Halt with a full buffer
        rdy_pct = 0;
        tick(1'b1, 1'b0, '0);
        repeat (10) tick0();
        check("t5_full", 32'(instr_valid), 32'h1);
        halt_q = 1; rdy_pct = 100;
        d0 = delivered;
        repeat (6) tick0();
        check("t5_drained", 32'(delivered - d0), 32'd2);
        check("t5_valid", 32'(instr_valid), 32'h0);
        check("t5_bubble", 32'(instruction), 32'(BUB));
        check("t5_no_req", 32'(mem_req), 32'h0);
        halt_q = 0;
        for (int i = 0; i < 10 && !mem_req; i++) tick0();
        check("t5_resume_addr", mem_addr, 32'd2);

        // Reset while a read is in flight; stale data must be dropped
        lat_min = 4; lat_max = 4;
        tick(1'b1, 1'b0, '0);
        for (int i = 0; i < 20 && !out_pending; i++) tick0();
        check("t6_in_flight", 32'(out_pending), 32'h1);
        out_data = 16'hFFFF;
        tick(1'b1, 1'b0, '0);
        d0 = delivered;
        for (int i = 0; i < 40 && delivered == d0; i++) tick0();
        check("t6_first_pc", last_pop_pc, RPC);
        check("t6_first_ins", 32'(last_pop_ins), 32'h1000);

        // Random traffic, redirects (including near PC wrap) and halt windows
        tick(1'b1, 1'b0, '0);
        d0 = delivered;
        for (int seg = 0; seg < 40; seg++) begin
            gnt_pct = int'($urandom_range(30, 100));
            rdy_pct = int'($urandom_range(20, 100));
            lat_min = 1;
            lat_max = int'($urandom_range(1, 4));
            halt_q  = ($urandom_range(0, 9) == 0);
            for (int k = 0; k < 60; k++) begin
                if ($urandom_range(0, 29) == 0)
                    tick(1'b0, 1'b1, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom);
                else
                    tick0();
            end
        end
        check("rand_progress", 32'((delivered - d0) >= 100), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
